// File: rtl/reg8_pkg.sv
// Shared geometry and read-sequencer state encoding for the 8-entry x 8-bit register file.
package reg8_pkg;

  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_e;

endpackage

// File: rtl/reg8_dump.sv
// Walks a wrap-around address range of the register file and streams each
// captured byte, tagged with its address, over a valid/ready interface.
module reg8_dump #(
  parameter int NREGS = reg8_pkg::NREGS,
  parameter int AW    = reg8_pkg::AW,
  parameter int DW    = reg8_pkg::DW
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  import reg8_pkg::*;

  localparam logic [AW:0] NREGS_CNT = (AW+1)'(NREGS);

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW:0]   remaining_q;
  logic [DW-1:0] out_data_q;
  logic [AW-1:0] out_addr_q;
  logic          out_last_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;

  logic [AW:0]   count_clamped;
  logic [AW-1:0] ptr_d;

  // Requests larger than the file are clamped; the pointer wraps naturally
  // because NREGS is a power of two.
  always_comb begin
    count_clamped = (count > NREGS_CNT) ? NREGS_CNT : count;
    ptr_d         = ptr_q + AW'(1);
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates at the edge see the same pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              ptr_q       <= base;
              remaining_q <= count_clamped;
              busy_q      <= 1'b1;
              state_q     <= FETCH;
            end
          end
        end

        FETCH: begin
          // Snapshot of the file: later writes do not disturb this beat.
          out_data_q  <= rd_data;
          out_addr_q  <= ptr_q;
          out_last_q  <= (remaining_q == (AW+1)'(1));
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ptr_q       <= ptr_d;
              remaining_q <= remaining_q - (AW+1)'(1);
              state_q     <= FETCH;
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_addr   = ptr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/reg8_dump.md
# reg8_dump

Read-side sequencer for the 8-entry × 8-bit register file. On a start pulse it walks a contiguous, wrap-around range of register addresses and reads each entry through the file's combinational read port. It presents each byte, tagged with its address, on a valid/ready output stream and pulses done after the last beat. It sits between the register file's read port and any downstream consumer, such as a debug dump or a UART transmitter.

## Interface
Parameters:
- NREGS, 8, number of registers in the file.
- AW, 3, address width (log2 NREGS).
- DW, 8, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- base  in  AW  first address to read; sampled with start.
- count  in  AW+1  number of registers to read; sampled with start.
- rd_addr  out  AW  address to the register file read port.
- rd_data  in  DW  register file read data, combinational from rd_addr.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DW  captured register value.
- out_addr  out  AW  address the beat was read from.
- out_last  out  1  high on the final beat of the dump.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final handshake.

## Operation
- State machine: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 with count≥1: latch ptr=base and remaining=min(count, NREGS), then go to FETCH.
  - start=1 with count=0: go directly to DONE; no beats are produced.
- FETCH:
  - Drive rd_addr=ptr.
  - At the clock edge, capture out_data←rd_data, out_addr←ptr, and out_last←(remaining==1).
  - Then go to SEND.
- SEND:
  - out_valid=1, and out_data, out_addr and out_last are held stable until out_ready=1.
  - On handshake with out_last=1: go to DONE.
  - On handshake with out_last=0: ptr←(ptr+1) mod NREGS, remaining←remaining−1, then go to FETCH.
- DONE: done=1 for one cycle, then return to IDLE.
- Address arithmetic is modulo NREGS. Example: base=6, count=4 reads 6, 7, 0, 1.
- The captured byte is a snapshot. A register-file write after the FETCH edge does not change an in-flight beat. A write before the FETCH edge is reflected in that beat.
- start is ignored in FETCH, SEND and DONE, with no queuing.
- rd_addr holds ptr in every state. Its value is don't-care outside FETCH but must be stable.

## Timing
- Reset values: out_valid=0, out_data=0, out_addr=0, out_last=0, rd_addr=0, busy=0, done=0, state=IDLE.
- Reset is asynchronous. Asserting clr_n low mid-dump abandons the dump immediately: out_valid drops without a handshake and no done pulse is produced.
- Latency: start accepted at edge 0 → FETCH in cycle 1 → out_valid=1 in cycle 2.
- Throughput: 2 cycles per beat with out_ready held high. Each stall cycle adds 1.
- A count=N dump with out_ready=1 throughout: done pulses in cycle 2N+1, and busy is high in cycles 1..2N.
- A count=0 request: done in cycle 1 and busy stays 0.
- busy=0 and done=1 in the DONE cycle. A start in that cycle is ignored; the next start is accepted in the following cycle.

## Structure
- Shared package reg8_pkg:
  - Constants NREGS=8, AW=3, DW=8.
  - The state enum (IDLE, FETCH, SEND, DONE).
  - The register-file geometry is shared with the write side.
- Single module with no sub-module. The ptr/remaining counter and the output holding register are inline sequential logic on clk/clr_n.

## Test plan
- Basic dump: file preloaded with reg[i]=8'h10+i; base=0, count=8, out_ready=1.
  - Beats 10..17 arrive with addresses 0..7, out_last only on address 7.
  - done pulses in cycle 17.
- Wrap: base=6, count=4 → addresses 6, 7, 0, 1 with matching data; out_last on address 1.
- Back-pressure: out_ready=0 for 5 cycles on the second beat.
  - out_valid, out_data and out_addr are held constant throughout.
  - The dump completes 5 cycles later than the unstalled case.
- Boundaries:
  - count=0 → no out_valid, done in cycle 1.
  - count=12 → clamped to 8 beats.
  - start pulsed during SEND → ignored, and the beat count is unchanged.
- Snapshot: write reg[3]=8'hAA while the beat for address 3 is stalled in SEND.
  - The beat still carries the old value.
  - A second dump reads 8'hAA.
- Reset mid-dump: clr_n low while in SEND.
  - All outputs read 0 immediately, before any clock edge.
  - No done pulse.
  - After release, a new start behaves exactly as in the basic dump.
